// File: rtl/fir_pkg.sv
// Shared constants for the FIR control front end: register addresses,
// ap_ctrl bit positions and the run-state encoding.
package fir_pkg;

    localparam logic [31:0] ADDR_AP_CTRL  = 32'h0000_0000;
    localparam logic [31:0] ADDR_DLEN     = 32'h0000_0010;
    localparam logic [31:0] ADDR_TAP_BASE = 32'h0000_0020;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // True when a byte address falls inside the tap coefficient window.
    function automatic logic in_tap(input logic [31:0] addr, input int num);
        return (addr >= ADDR_TAP_BASE) && (addr < ADDR_TAP_BASE + 32'(4 * num));
    endfunction

endpackage

// File: rtl/fir_axil_slave.sv
// AXI-Lite handshake and read pipeline; serialises one transaction at a time
// and presents a simple request bus to the controller.
module fir_axil_slave #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          awvalid,
    output logic          awready,
    input  logic [AW-1:0] awaddr,
    input  logic          wvalid,
    output logic          wready,
    input  logic [DW-1:0] wdata,
    input  logic          arvalid,
    output logic          arready,
    input  logic [AW-1:0] araddr,
    output logic          rvalid,
    input  logic          rready,
    output logic [DW-1:0] rdata,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          vld_wr_p1,
    output logic          vld_rd_p1,
    output logic [AW-1:0] addr_p1,
    output logic [DW-1:0] data_p1,
    input  logic [DW-1:0] rd_data,
    output logic          rd_done
);

    logic vld_rd_p2;
    logic ar_hs;
    logic busy;

    assign wr_req  = awvalid && awready && wvalid && wready;
    assign wr_addr = awaddr;
    assign wr_data = wdata;
    assign ar_hs   = arvalid && arready;
    assign rd_done = rvalid && rready;
    // Nothing new is accepted until the previous transaction has fully retired.
    assign busy    = awready || arready || vld_wr_p1 || vld_rd_p1 || vld_rd_p2 || rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready   <= 1'b0;
            wready    <= 1'b0;
            arready   <= 1'b0;
            vld_wr_p1 <= 1'b0;
            vld_rd_p1 <= 1'b0;
            vld_rd_p2 <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            awready   <= !busy && awvalid && wvalid;
            wready    <= !busy && awvalid && wvalid;
            arready   <= !busy && arvalid && !(awvalid && wvalid);
            // p1: address/data presented to the controller and the tap port
            vld_wr_p1 <= wr_req;
            vld_rd_p1 <= ar_hs;
            // p2: BRAM data available, captured into rdata
            vld_rd_p2 <= vld_rd_p1;
            if (vld_rd_p2) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
            end else if (rd_done) begin
                rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_req) begin
            addr_p1 <= awaddr;
            data_p1 <= wdata;
        end else if (ar_hs) begin
            addr_p1 <= araddr;
        end
    end

endmodule

// File: rtl/fir_ap_ctrl.sv
// FIR control front end: register file, run sequencing and tap BRAM
// arbitration between AXI-Lite (idle) and the MAC engine (running).
module fir_ap_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic                   eng_start,
    input  logic                   out_beat,
    output logic                   eng_last,
    output logic                   eng_running
);

    logic                   wr_req;
    logic [pADDR_WIDTH-1:0] wr_addr;
    logic [pDATA_WIDTH-1:0] wr_data;
    logic                   vld_wr_p1;
    logic                   vld_rd_p1;
    logic [pADDR_WIDTH-1:0] addr_p1;
    logic [pDATA_WIDTH-1:0] data_p1;
    logic [pDATA_WIDTH-1:0] rd_data;
    logic                   rd_done;

    logic [0:0]             state;
    logic                   ap_done;
    logic [pDATA_WIDTH-1:0] data_length;
    logic [pDATA_WIDTH-1:0] out_cnt;
    logic [pDATA_WIDTH-1:0] ctrl_word;
    logic [31:0]            wr_addr32;
    logic [31:0]            addr32_p1;
    logic                   running;
    logic                   tap_hit_p1;
    logic                   start_req;
    logic                   finish;

    fir_axil_slave #(
        .AW(pADDR_WIDTH),
        .DW(pDATA_WIDTH)
    ) u_axil (
        .clk      (axis_clk),
        .rst_n    (axis_rst_n),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .vld_wr_p1(vld_wr_p1),
        .vld_rd_p1(vld_rd_p1),
        .addr_p1  (addr_p1),
        .data_p1  (data_p1),
        .rd_data  (rd_data),
        .rd_done  (rd_done)
    );

    assign wr_addr32   = 32'(wr_addr);
    assign addr32_p1   = 32'(addr_p1);
    assign running     = (state == RUN);
    assign tap_hit_p1  = in_tap(addr32_p1, Tape_Num);
    assign start_req   = wr_req && (wr_addr32 == ADDR_AP_CTRL) && wr_data[AP_START_BIT]
                         && !running && (data_length != '0);
    assign finish      = running && out_beat && (out_cnt == data_length - 1'b1);
    assign eng_last    = running && (out_cnt == data_length - 1'b1);
    assign eng_running = running;

    always_comb begin
        ctrl_word               = '0;
        ctrl_word[AP_START_BIT] = start_req;
        ctrl_word[AP_DONE_BIT]  = ap_done;
        ctrl_word[AP_IDLE_BIT]  = !running;
    end

    always_comb begin
        rd_data = '0;
        if (addr32_p1 == ADDR_AP_CTRL) begin
            rd_data = ctrl_word;
        end else if (addr32_p1 == ADDR_DLEN) begin
            rd_data = data_length;
        end else if (tap_hit_p1) begin
            // The engine owns the coefficients while running; AXI sees all ones.
            rd_data = running ? '1 : tap_Do;
        end
    end

    always_comb begin
        tap_EN = 1'b1;
        tap_WE = 4'h0;
        tap_Di = '0;
        tap_A  = '0;
        if (running) begin
            tap_A = eng_tap_A;
        end else if ((vld_wr_p1 || vld_rd_p1) && tap_hit_p1) begin
            tap_A = pADDR_WIDTH'(addr32_p1 - ADDR_TAP_BASE);
            if (vld_wr_p1) begin
                tap_WE = 4'hF;
                tap_Di = data_p1;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state       <= IDLE;
            eng_start   <= 1'b0;
            ap_done     <= 1'b0;
            data_length <= '0;
            out_cnt     <= '0;
        end else begin
            eng_start <= start_req;
            if (start_req) begin
                state <= RUN;
            end else if (finish) begin
                state <= IDLE;
            end
            // A done set on the same edge as a clearing read takes priority.
            if (finish) begin
                ap_done <= 1'b1;
            end else if (rd_done && (addr32_p1 == ADDR_AP_CTRL)) begin
                ap_done <= 1'b0;
            end
            if (wr_req && (wr_addr32 == ADDR_DLEN) && !running) begin
                data_length <= wr_data;
            end
            if (start_req) begin
                out_cnt <= '0;
            end else if (running && out_beat) begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// Randomised bench for fir_ap_ctrl against a register/run-level reference model
// with a bench-side tap BRAM of one-cycle read latency.
module tb_fir_ap_ctrl;

    localparam int NT = 11;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, arready, rvalid;
    logic [11:0] awaddr = '0, araddr = '0, eng_tap_A = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [31:0] tap_Di;
    logic [11:0] tap_A;
    logic [31:0] tap_Do = '0;
    logic        eng_start, eng_last, eng_running;
    logic        out_beat = 1'b0;

    fir_ap_ctrl dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .tap_WE     (tap_WE),
        .tap_EN     (tap_EN),
        .tap_Di     (tap_Di),
        .tap_A      (tap_A),
        .tap_Do     (tap_Do),
        .eng_tap_A  (eng_tap_A),
        .eng_start  (eng_start),
        .out_beat   (out_beat),
        .eng_last   (eng_last),
        .eng_running(eng_running)
    );

    always #5 axis_clk = ~axis_clk;

    logic [31:0] bram [0:1023];
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) bram[tap_A[11:2]] <= tap_Di;
            tap_Do <= bram[tap_A[11:2]];
        end
    end

    int start_seen = 0;
    always @(negedge axis_clk) if (eng_start) start_seen++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", tag, obs, exp);
        end
    endtask

    // Reference model: register contents and run progress.
    logic [31:0] m_tap [0:NT-1];
    bit          m_run = 0, m_done = 0;
    logic [31:0] m_dlen = '0;
    int          m_beats = 0;

    function automatic bit m_is_tap(input logic [11:0] a);
        return (a >= 12'h020) && (a < 12'h020 + 12'(4 * NT));
    endfunction

    function automatic logic [31:0] m_value(input logic [11:0] a);
        if (a == 12'h000) return {29'b0, !m_run, m_done, 1'b0};
        if (a == 12'h010) return m_dlen;
        if (m_is_tap(a)) return m_run ? 32'hFFFF_FFFF : m_tap[(a - 12'h020) >> 2];
        return 32'h0;
    endfunction

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, output logic [3:0] we,
                             output logic [11:0] ta, output logic [31:0] di, output logic es,
                             output bit ok);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge axis_clk);
            if (awready && wready) begin ok = 1; break; end
        end
        if (ok) begin @(posedge axis_clk); #1; end
        awvalid = 1'b0; wvalid = 1'b0;
        we = tap_WE; ta = tap_A; di = tap_Di; es = eng_start;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output int lat,
                            output bit ok, output bit hold, output bit gone);
        araddr = a; arvalid = 1'b1; ok = 0; lat = 0; d = '0; hold = 0; gone = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge axis_clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) begin arvalid = 1'b0; return; end
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        ok = 0;
        for (int i = 1; i < 50; i++) begin
            @(posedge axis_clk); #1;
            if (rvalid) begin lat = i; ok = 1; break; end
        end
        if (!ok) return;
        d = rdata;
        @(posedge axis_clk); #1;
        hold = rvalid && (rdata == d);
        rready = 1'b1;
        @(posedge axis_clk); #1;
        rready = 1'b0;
        gone = !rvalid;
    endtask

    task automatic m_write(input logic [11:0] a, input logic [31:0] d);
        logic [3:0]  we;
        logic [11:0] ta;
        logic [31:0] di;
        logic        es;
        bit          ok, exp_start;
        axi_write(a, d, we, ta, di, es, ok);
        if (!ok) begin check_val("wr_timeout", 0, 1); return; end
        check_val($sformatf("tap_we@%h", a), {28'b0, we},
                  (!m_run && m_is_tap(a)) ? 32'hF : 32'h0);
        if (!m_run && m_is_tap(a)) begin
            check_val($sformatf("tap_a@%h", a), {20'b0, ta}, {20'b0, a - 12'h020});
            check_val($sformatf("tap_di@%h", a), di, d);
        end
        exp_start = (a == 12'h000) && d[0] && !m_run && (m_dlen != 0);
        check_val($sformatf("eng_start@%h", a), {31'b0, es}, {31'b0, exp_start});
        if (exp_start) begin
            m_run = 1; m_beats = 0;
            check_val("running_on_start", {31'b0, eng_running}, 32'h1);
        end
        if (a == 12'h010 && !m_run) m_dlen = d;
        if (m_is_tap(a) && !m_run) m_tap[(a - 12'h020) >> 2] = d;
    endtask

    task automatic m_read(input logic [11:0] a);
        logic [31:0] d, exp;
        int          lat;
        bit          ok, hold, gone;
        exp = m_value(a);
        axi_read(a, d, lat, ok, hold, gone);
        if (!ok) begin check_val("rd_timeout", 0, 1); return; end
        check_val($sformatf("rd_lat@%h", a), lat, 2);
        check_val("rd_hold", {31'b0, hold}, 32'h1);
        check_val($sformatf("rdata@%h", a), d, exp);
        check_val("rvalid_clear", {31'b0, gone}, 32'h1);
        if (a == 12'h000) m_done = 0;
    endtask

    task automatic m_beat();
        eng_tap_A = 12'($urandom_range(0, 4095));
        #1;
        if (m_run) begin
            check_val("run_tap_a", {20'b0, tap_A}, {20'b0, eng_tap_A});
            check_val("run_tap_we", {28'b0, tap_WE}, 32'h0);
        end
        check_val($sformatf("eng_last_b%0d", m_beats),
                  {31'b0, eng_last}, {31'b0, (m_run && (m_beats == int'(m_dlen) - 1))});
        out_beat = 1'b1;
        @(posedge axis_clk); #1;
        out_beat = 1'b0;
        if (m_run) begin
            m_beats++;
            if (m_beats == int'(m_dlen)) begin m_run = 0; m_done = 1; end
        end
        check_val("eng_running", {31'b0, eng_running}, {31'b0, m_run});
    endtask

    task automatic reset_checks(input string pfx);
        check_val({pfx, "_ready"}, {29'b0, awready, wready, arready}, 32'h0);
        check_val({pfx, "_rvalid"}, {31'b0, rvalid}, 32'h0);
        check_val({pfx, "_rdata"}, rdata, 32'h0);
        check_val({pfx, "_tap"}, {tap_WE, tap_EN, 15'b0, tap_A}, {4'h0, 1'b1, 15'b0, 12'h0});
        check_val({pfx, "_tap_di"}, tap_Di, 32'h0);
        check_val({pfx, "_eng"}, {29'b0, eng_start, eng_last, eng_running}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit, want self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a;
        logic [31:0] v;
        int          s0, dl, k;
        bit          ok;

        repeat (3) @(posedge axis_clk);
        #1;
        reset_checks("in_reset");
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        reset_checks("post_reset");
        m_read(12'h000);

        for (int i = 0; i < NT; i++) m_write(12'h020 + 12'(4 * i), 32'(i));
        m_read(12'h028);

        // Random idle-time register traffic, including unmapped addresses.
        repeat (24) begin
            k = $urandom_range(0, 5);
            case (k)
                0: a = 12'h000;
                1: a = 12'h010;
                2, 3: a = 12'h020 + 12'(4 * $urandom_range(0, NT - 1));
                4: a = 12'h004 + 12'(16 * $urandom_range(0, 3));
                default: a = 12'h04C + 12'(4 * $urandom_range(0, 40));
            endcase
            v = $urandom;
            if (a == 12'h000) v[0] = 1'b0;
            if ($urandom_range(0, 1) == 0) m_write(a, v);
            else m_read(a);
        end

        // Directed three-output run.
        m_write(12'h010, 32'd3);
        m_read(12'h010);
        m_read(12'h000);
        s0 = start_seen;
        m_write(12'h000, 32'd1);
        m_read(12'h000);
        m_write(12'h024, 32'd99);
        m_read(12'h024);
        m_write(12'h010, 32'd7);
        m_write(12'h000, 32'd1);
        check_val("one_start", 32'(start_seen - s0), 32'd1);
        repeat (3) m_beat();
        m_read(12'h000);
        m_read(12'h000);
        m_read(12'h024);
        m_read(12'h010);

        // Random runs with random gaps, mid-run tap reads and stray idle beats.
        repeat (4) begin
            dl = $urandom_range(1, 6);
            m_write(12'h010, 32'(dl));
            s0 = start_seen;
            m_write(12'h000, 32'd1);
            for (int b = 0; b < dl; b++) begin
                repeat ($urandom_range(0, 3)) @(posedge axis_clk);
                #1;
                if ($urandom_range(0, 2) == 0) m_read(12'h020 + 12'(4 * $urandom_range(0, NT - 1)));
                m_beat();
            end
            m_beat();
            check_val("run_starts", 32'(start_seen - s0), 32'd1);
            m_read(12'h000);
            m_read(12'h020 + 12'(4 * $urandom_range(0, NT - 1)));
        end

        // Start with zero length must not launch a run.
        m_write(12'h010, 32'd0);
        s0 = start_seen;
        m_write(12'h000, 32'd1);
        repeat (3) @(posedge axis_clk);
        #1;
        check_val("zero_len_start", 32'(start_seen - s0), 32'd0);
        check_val("zero_len_running", {31'b0, eng_running}, 32'h0);
        m_read(12'h000);

        // Simultaneous write and read to the same tap: the write must go first.
        v = $urandom;
        awaddr = 12'h030; wdata = v; araddr = 12'h030;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge axis_clk);
            if (awready || arready) begin ok = 1; break; end
        end
        check_val("arb_write_first", {30'b0, awready, arready}, 32'h2);
        if (ok) begin @(posedge axis_clk); #1; end
        awvalid = 1'b0; wvalid = 1'b0;
        m_tap[4] = v;
        m_read(12'h030);

        // Reset in the middle of a run.
        m_write(12'h010, 32'd3);
        m_write(12'h000, 32'd1);
        m_beat();
        eng_tap_A = 12'h014;
        axis_rst_n = 1'b0;
        #1;
        reset_checks("mid_run_reset");
        m_run = 0; m_done = 0; m_dlen = '0;
        repeat (2) @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        m_read(12'h000);
        m_read(12'h010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
